// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur runner game core:
// game state encoding, divider sizing, BCD limits and segment patterns.
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    JUMP = 3'd2,
    DUCK = 3'd3,
    OVER = 3'd4
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int div_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Segment patterns, a..g on bits 0..6, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal codes blank.
module seg7_bcd_decoder
  import dino_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pattern lookup with blank as the fallback for 10..15
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dino_game_core.sv
// Dinosaur runner game core: tick-driven game FSM, saturating BCD score with
// high-score retention, and a multiplexed seven-segment score display.
// Everything runs on clk_in; slow timebases are single-cycle enable ticks.
module dino_game_core
  import dino_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GAME_HZ    = 5,
  parameter int SCAN_HZ    = 1_000,
  parameter int JUMP_TICKS = 3,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    btn_start,
  input  logic                    btn_jump,
  input  logic                    btn_duck,
  input  logic                    obs_low,
  input  logic                    obs_high,
  output logic                    game_tick,
  output logic                    led_idle,
  output logic                    led_run,
  output logic                    led_jump,
  output logic                    led_duck,
  output logic                    led_over,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hi_score,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int GAME_DIV = CLK_HZ / GAME_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int GW       = div_width(GAME_DIV);
  localparam int SW       = div_width(SCAN_DIV);
  localparam int JW       = div_width(JUMP_TICKS);
  localparam int DW       = div_width(NUM_DIGITS);

  logic [GW-1:0] game_cnt;
  logic [SW-1:0] scan_cnt;
  logic          scan_tick;

  state_t        state_q;
  state_t        state_d;
  logic [JW-1:0] jump_cnt;
  logic [JW-1:0] jump_d;
  logic          restart;
  logic          in_play;

  logic [NUM_DIGITS-1:0]   nine;
  logic [NUM_DIGITS-1:0]   carry;
  logic [4*NUM_DIGITS-1:0] score_inc;

  logic [DW-1:0]           dig_idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [3:0]              nibble;
  logic [6:0]              seg_d;

  // Game timebase: wrapping divider whose terminal count registers one tick
  always_ff @(posedge clk_in) begin
    if (reset) begin
      game_cnt  <= '0;
      game_tick <= 1'b0;
    end else begin
      game_tick <= (game_cnt == GW'(GAME_DIV - 1));
      game_cnt  <= (game_cnt == GW'(GAME_DIV - 1)) ? '0 : game_cnt + 1'b1;
    end
  end

  // Scan timebase: same structure as the game divider
  always_ff @(posedge clk_in) begin
    if (reset) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt == SW'(SCAN_DIV - 1));
      scan_cnt  <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
    end
  end

  // Game rules; the result is only committed on game ticks
  always_comb begin
    state_d = state_q;
    jump_d  = jump_cnt;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        if (obs_low || obs_high) begin
          state_d = OVER;
        end else if (btn_jump) begin
          state_d = JUMP;
          jump_d  = JW'(JUMP_TICKS - 1);
        end else if (btn_duck) begin
          state_d = DUCK;
        end
      end
      JUMP: begin
        if (obs_high) begin
          state_d = OVER;
        end else if (jump_cnt == '0) begin
          state_d = RUN;
        end else begin
          jump_d = jump_cnt - 1'b1;
        end
      end
      DUCK: begin
        if (obs_low) begin
          state_d = OVER;
        end else if (!btn_duck) begin
          state_d = RUN;
        end
      end
      OVER: begin
        if (btn_start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and airborne counter advance once per game tick
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      jump_cnt <= '0;
    end else if (game_tick) begin
      state_q  <= state_d;
      jump_cnt <= jump_d;
    end
  end

  assign led_idle = (state_q == IDLE);
  assign led_run  = (state_q == RUN);
  assign led_jump = (state_q == JUMP);
  assign led_duck = (state_q == DUCK);
  assign led_over = (state_q == OVER);

  // BCD ripple increment; an all-nines score blocks the carry-in to saturate
  assign carry[0] = ~(&nine);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bcd
    logic [3:0] d;
    assign d       = score[4*g +: 4];
    assign nine[g] = (d == DIGIT_MAX);
    assign score_inc[4*g +: 4] = carry[g] ? (nine[g] ? 4'd0 : d + 4'd1) : d;
    if (g < NUM_DIGITS - 1) begin : g_carry
      assign carry[g+1] = carry[g] & nine[g];
    end
  end

  assign in_play = (state_d == RUN) || (state_d == JUMP) || (state_d == DUCK);

  // Score counts surviving ticks; best score latches on the crash tick
  always_ff @(posedge clk_in) begin
    if (reset) begin
      score    <= '0;
      hi_score <= '0;
    end else if (game_tick) begin
      if (restart) begin
        score <= '0;
      end else if (in_play) begin
        score <= score_inc;
      end
      if ((state_d == OVER) && (state_q != OVER) && (score > hi_score)) begin
        hi_score <= score;
      end
    end
  end

  // The idle attract screen shows the best score, play shows the live one
  assign disp = (state_q == IDLE) ? hi_score : score;

  // Select the nibble of the digit currently being scanned
  always_comb begin
    nibble = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == DW'(i)) nibble = disp[4*i +: 4];
    end
  end

  seg7_bcd_decoder u_decoder (
    .nibble (nibble),
    .seg    (seg_d)
  );

  // Light the indexed digit on each scan tick, then move to the next one
  always_ff @(posedge clk_in) begin
    if (reset) begin
      dig_idx <= '0;
      an      <= '1;
      seg     <= '0;
    end else if (scan_tick) begin
      an      <= ~(NUM_DIGITS'(1) << dig_idx);
      seg     <= seg_d;
      dig_idx <= (dig_idx == DW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end
  end

endmodule
